// File: rtl/mem_access_if.sv
// Data-bus bundle between the memory-access stage (master) and the data memory (slave).
interface mem_access_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
    input  bus_ack_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
    output bus_ack_i, bus_rdata_i
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues lw/sw on a registered data bus and muxes writeback.
// Optional bus-wait abort is enabled by defining MEM_ACCESS_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | pass ALU writeback through, or launch an aligned lw/sw
// ACCESS | bus request held until ack (or timeout abort)
// DONE   | one cycle of lw writeback / timeout report, pipeline released
module mem_access #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         alu_op_i,
  input  logic [31:0]        mem_addr_i,
  input  logic [31:0]        store_data_i,
  input  logic               write_reg_i,
  input  logic [4:0]         write_data_num_i,
  input  logic [31:0]        write_data_i,
  mem_access_if.master       bus,
  output logic               write_reg_o,
  output logic [4:0]         write_data_num_o,
  output logic [31:0]        write_data_o,
  output logic               stall_o,
  output logic               misalign_o,
  output logic               timeout_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [4:0] OP_LW = 5'b10100;
  localparam logic [4:0] OP_SW = 5'b10101;

  logic [1:0]  state;
  logic [4:0]  rd_q;
  logic        lw_q;
  logic [31:0] rdata_q;

  logic is_mem;
  logic aligned;
  logic start;

  assign is_mem  = (alu_op_i == OP_LW) || (alu_op_i == OP_SW);
  assign aligned = (mem_addr_i[1:0] == 2'b00);
  assign start   = is_mem && aligned;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt;
  logic             to_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bus.bus_req_o   <= 1'b0;
      bus.bus_we_o    <= 1'b0;
      bus.bus_addr_o  <= 32'h0;
      bus.bus_wdata_o <= 32'h0;
      rdata_q         <= 32'h0;
      rd_q            <= 5'h0;
      lw_q            <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt             <= '0;
      to_q            <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state           <= ACCESS;
            bus.bus_req_o   <= 1'b1;
            bus.bus_we_o    <= (alu_op_i == OP_SW);
            bus.bus_addr_o  <= {2'b00, mem_addr_i[31:2]};
            bus.bus_wdata_o <= store_data_i;
            rd_q            <= write_data_num_i;
            lw_q            <= (alu_op_i == OP_LW);
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt             <= '0;
            to_q            <= 1'b0;
`endif
          end
        end
        ACCESS: begin
          // ack in the final allowed cycle still completes the access normally
          if (bus.bus_ack_i) begin
            rdata_q       <= bus.bus_rdata_i;
            bus.bus_req_o <= 1'b0;
            state         <= DONE;
          end
`ifdef MEM_ACCESS_TIMEOUT_EN
          else if (cnt == CNT_LAST) begin
            bus.bus_req_o <= 1'b0;
            to_q          <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
`ifdef MEM_ACCESS_TIMEOUT_EN
          to_q  <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    write_reg_o      = 1'b0;
    write_data_num_o = 5'h0;
    write_data_o     = 32'h0;
    stall_o          = 1'b0;
    misalign_o       = 1'b0;
    timeout_o        = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (is_mem) begin
            misalign_o = ~aligned;
            stall_o    = aligned;
          end else begin
            write_reg_o      = write_reg_i;
            write_data_num_o = write_data_num_i;
            write_data_o     = write_data_i;
          end
        end
        ACCESS: stall_o = 1'b1;
        DONE: begin
          write_data_num_o = rd_q;
          write_data_o     = rdata_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
          write_reg_o      = lw_q & ~to_q;
          timeout_o        = to_q;
`else
          write_reg_o      = lw_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
